cart_loader: RTL and testbench

Sits between the HPS download stream and the Vectrex core's cartridge port. Captures `ioctl_*` write bytes into an internal 32 KiB cartridge RAM and derives the power-of-two address mask from the highest address written. Sequences the core reset around a load and serves CPU cartridge reads with mirroring applied. Replaces the ad-hoc mask logic in the top level; the core sees only `cart_dout`, `cart_mask` and `core_reset`.

---
 rtl/cart_pkg.sv | 28 ++
 rtl/cart_ram.sv | 24 ++
 rtl/cart_loader.sv | 169 ++++++++++++++++
 tb/tb_cart_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the Vectrex cartridge loader.
package cart_pkg;

  localparam int CART_AW_DEF = 15;
  localparam int IOCTL_AW    = 25;
  localparam int HDR_LEN     = 5;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    HOLD,
    READY
  } state_e;

  // Vectrex copyright string "g GCE" expected at the start of every image.
  localparam logic [7:0] HEADER [HDR_LEN] = '{8'h67, 8'h20, 8'h47, 8'h43, 8'h45};

  // Sets every bit at and below the highest set bit; smear(0) = 0.
  function automatic logic [IOCTL_AW-1:0] smear(input logic [IOCTL_AW-1:0] a);
    logic [IOCTL_AW-1:0] r;
    r[IOCTL_AW-1] = a[IOCTL_AW-1];
    for (int i = IOCTL_AW - 2; i >= 0; i--) begin
      r[i] = a[i] | r[i+1];
    end
    return r;
  endfunction

endpackage

// File: rtl/cart_ram.sv
// Simple dual-port cartridge RAM: one write port, one registered read port.
module cart_ram #(
  parameter int AW = 15
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  // NOTE: the array has no reset so it maps onto block RAM; contents are only
  // read after a completed load has overwritten the region in use.
  logic [7:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/cart_loader.sv
// Captures the HPS cartridge download, derives the mirroring mask and sequences core reset.
// Optional header validation is built when CART_HEADER_CHECK_EN is defined.
module cart_loader
  import cart_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int CART_AW     = CART_AW_DEF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic [CART_AW-1:0] cpu_addr,
  output logic [7:0]         cart_dout,
  output logic [CART_AW-1:0] cart_mask,
  output logic               core_reset,
  output logic               load_done,
  output logic               oversize,
  output logic               header_ok
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_e             state_q, state_d;
  logic               dl_q;
  logic [CART_AW-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               core_reset_q, core_reset_d;
  logic               load_done_q, load_done_d;
  logic               oversize_q, oversize_d;
  logic               rd_valid_q;

  logic                dl_rise, dl_fall, wr_active, addr_ok, ram_we;
  logic [IOCTL_AW-1:0] smear_full;
  logic [CART_AW-1:0]  wr_smear;
  logic [7:0]          ram_rdata;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign wr_active  = ioctl_wr && (state_q == LOAD || dl_rise);
  assign smear_full = smear(ioctl_addr);
  // Any smeared bit at or above CART_AW means the address lies outside the RAM.
  assign addr_ok    = ~|smear_full[IOCTL_AW-1:CART_AW];
  assign wr_smear   = smear_full[CART_AW-1:0];
  assign ram_we     = wr_active & addr_ok;

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    core_reset_d = core_reset_q;
    load_done_d  = load_done_q;
    oversize_d   = oversize_q;

    if (dl_rise) begin
      state_d      = LOAD;
      mask_d       = '0;
      cnt_d        = '0;
      core_reset_d = 1'b1;
      load_done_d  = 1'b0;
      oversize_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (dl_fall) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d      = READY;
            core_reset_d = 1'b0;
            load_done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Applied after the entry clear so a byte on the rising edge sees a zero mask.
    if (wr_active) begin
      if (addr_ok) begin
        mask_d = mask_d | wr_smear;
      end else begin
        oversize_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= EMPTY;
      dl_q         <= 1'b0;
      mask_q       <= '0;
      cnt_q        <= '0;
      core_reset_q <= 1'b0;
      load_done_q  <= 1'b0;
      oversize_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      oversize_q   <= oversize_d;
      rd_valid_q   <= (state_d == READY);
    end
  end

  cart_ram #(
    .AW(CART_AW)
  ) u_ram (
    .clk_i  (clk_sys),
    .we_i   (ram_we),
    .waddr_i(ioctl_addr[CART_AW-1:0]),
    .wdata_i(ioctl_dout),
    .raddr_i(cpu_addr & mask_q),
    .rdata_o(ram_rdata)
  );

  assign cart_dout  = rd_valid_q ? ram_rdata : 8'hFF;
  assign cart_mask  = mask_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign oversize   = oversize_q;

`ifdef CART_HEADER_CHECK_EN
  logic [HDR_LEN-1:0] hdr_match_q, hdr_match_d;
  logic               header_ok_q, header_ok_d;

  // A header byte counts only if its latest write in this load matched.
  always_comb begin
    hdr_match_d = dl_rise ? '0 : hdr_match_q;
    header_ok_d = dl_rise ? 1'b0 : header_ok_q;
    for (int i = 0; i < HDR_LEN; i++) begin
      if (ram_we && ioctl_addr == 25'(i)) begin
        hdr_match_d[i] = (ioctl_dout == HEADER[i]);
      end
    end
    if (state_q == HOLD && state_d == READY) begin
      header_ok_d = &hdr_match_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hdr_match_q <= '0;
      header_ok_q <= 1'b0;
    end else begin
      hdr_match_q <= hdr_match_d;
      header_ok_q <= header_ok_d;
    end
  end

  assign header_ok = header_ok_q;
`else
  assign header_ok = load_done_q;
`endif

endmodule

// File: tb/tb_cart_loader.sv
// Randomized self-checking bench for cart_loader against a byte-array reference model.
module tb_cart_loader;

  localparam int HOLD = 16;
  localparam int AW   = 15;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cart_dout;
  logic [AW-1:0] cart_mask;
  logic          core_reset, load_done, oversize, header_ok;

  int checks = 0;
  int errors = 0;

  // Reference model: RAM image, highest accepted address, oversize flag, header writes.
  logic [7:0] mem [1<<AW];
  int         max_addr;
  bit         ovs_exp;
  bit         hdr_wr [5];
  logic [7:0] hdr_ref [5] = '{8'h67, 8'h20, 8'h47, 8'h43, 8'h45};

  cart_loader #(.HOLD_CYCLES(HOLD), .CART_AW(AW)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .cpu_addr      (cpu_addr),
    .cart_dout     (cart_dout),
    .cart_mask     (cart_mask),
    .core_reset    (core_reset),
    .load_done     (load_done),
    .oversize      (oversize),
    .header_ok     (header_ok)
  );

  always #5 clk_sys = ~clk_sys;

  // Smallest 2^n-1 covering the highest accepted address.
  function automatic logic [AW-1:0] exp_mask();
    int m = 0;
    while (m < max_addr) m = m * 2 + 1;
    return AW'(m);
  endfunction

  function automatic bit exp_header();
`ifdef CART_HEADER_CHECK_EN
    bit ok = 1'b1;
    for (int i = 0; i < 5; i++) if (!hdr_wr[i] || mem[i] !== hdr_ref[i]) ok = 1'b0;
    return ok;
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_clear();
    max_addr = -1;
    ovs_exp  = 1'b0;
    for (int i = 0; i < 5; i++) hdr_wr[i] = 1'b0;
  endtask

  task automatic model_write(input logic [24:0] a, input logic [7:0] d);
    if (a < 25'(1 << AW)) begin
      mem[a[AW-1:0]] = d;
      if (int'(a) > max_addr) max_addr = int'(a);
      if (a < 25'd5) hdr_wr[int'(a)] = 1'b1;
    end else begin
      ovs_exp = 1'b1;
    end
  endtask

  task automatic drive_write(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    model_write(a, d);
  endtask

  task automatic load_range(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      drive_write(25'(i), 8'($urandom));
      if ($urandom_range(0, 7) == 0) tick();
    end
  endtask

  task automatic start_load();
    model_clear();
    ioctl_download = 1'b1;
    tick();
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL start_core_reset: got %b, expected 1", core_reset); end
    checks++; if (cart_mask !== '0) begin errors++; $display("FAIL start_mask: got %h, expected 0", cart_mask); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL start_load_done: got %b, expected 0", load_done); end
  endtask

  // Drops the download (optionally with a write on the same cycle) and follows the hold window.
  task automatic end_load(input bit with_wr, input logic [24:0] a, input logic [7:0] d);
    ioctl_download = 1'b0;
    if (with_wr) begin
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    end
    tick();
    ioctl_wr = 1'b0;
    if (with_wr) model_write(a, d);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      checks++; if (core_reset !== 1'b1 || load_done !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d: got core_reset=%b load_done=%b, expected 1/0", i, core_reset, load_done);
      end
    end
    tick();
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL ready_core_reset: got %b, expected 0", core_reset); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL ready_load_done: got %b, expected 1", load_done); end
    checks++; if (cart_mask !== exp_mask()) begin errors++; $display("FAIL ready_mask: got %h, expected %h", cart_mask, exp_mask()); end
    checks++; if (oversize !== ovs_exp) begin errors++; $display("FAIL ready_oversize: got %b, expected %b", oversize, ovs_exp); end
    checks++; if (header_ok !== exp_header()) begin errors++; $display("FAIL ready_header_ok: got %b, expected %b", header_ok, exp_header()); end
  endtask

  task automatic check_read(input logic [AW-1:0] a);
    logic [7:0] exp;
    cpu_addr = a;
    tick();
    exp = mem[a & exp_mask()];
    checks++; if (cart_dout !== exp) begin errors++; $display("FAIL read_%h: got %h, expected %h", a, cart_dout, exp); end
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) check_read(AW'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (cart_dout !== 8'hFF) begin errors++; $display("FAIL reset_dout: got %h, expected ff", cart_dout); end
    checks++; if (cart_mask !== '0) begin errors++; $display("FAIL reset_mask: got %h, expected 0", cart_mask); end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL reset_core_reset: got %b, expected 0", core_reset); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b, expected 0", load_done); end
    checks++; if (oversize !== 1'b0) begin errors++; $display("FAIL reset_oversize: got %b, expected 0", oversize); end
    checks++; if (header_ok !== 1'b0) begin errors++; $display("FAIL reset_header_ok: got %b, expected 0", header_ok); end
  endtask

  task automatic test_load_8k();
    start_load();
    load_range(0, 8192);
    end_load(1'b0, '0, '0);
    checks++; if (cart_mask !== 15'h1FFF) begin errors++; $display("FAIL 8k_mask: got %h, expected 1fff", cart_mask); end
    cpu_addr = 15'h2005;
    tick();
    checks++; if (cart_dout !== mem[5]) begin errors++; $display("FAIL 8k_mirror: got %h, expected %h", cart_dout, mem[5]); end
    random_reads(16);
  endtask

  task automatic test_load_3000();
    start_load();
    load_range(0, 3000);
    end_load(1'b0, '0, '0);
    checks++; if (cart_mask !== 15'h0FFF) begin errors++; $display("FAIL 3000_mask: got %h, expected 0fff", cart_mask); end
    cpu_addr = 15'h7010;
    tick();
    checks++; if (cart_dout !== mem[16'h0010]) begin errors++; $display("FAIL 3000_mirror: got %h, expected %h", cart_dout, mem[16'h0010]); end
    random_reads(16);
  endtask

  task automatic test_oversize();
    start_load();
    drive_write(25'h0008000, 8'hA5);
    checks++; if (oversize !== 1'b1) begin errors++; $display("FAIL ovs_flag: got %b, expected 1", oversize); end
    checks++; if (cart_mask !== '0) begin errors++; $display("FAIL ovs_mask: got %h, expected 0", cart_mask); end
    drive_write(25'h1FFFFFF, 8'h3C);
    drive_write(25'h0, 8'h5A);
    load_range(1, 1023);
    end_load(1'b0, '0, '0);
    checks++; if (cart_mask !== 15'h03FF) begin errors++; $display("FAIL ovs_final_mask: got %h, expected 03ff", cart_mask); end
    cpu_addr = 15'h0;
    tick();
    checks++; if (cart_dout !== 8'h5A) begin errors++; $display("FAIL ovs_ram0: got %h, expected 5a", cart_dout); end
    random_reads(8);
  endtask

  task automatic test_reset_mid_load();
    start_load();
    load_range(0, 300);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL mid_core_reset: got %b, expected 0", core_reset); end
    checks++; if (cart_dout !== 8'hFF) begin errors++; $display("FAIL mid_dout: got %h, expected ff", cart_dout); end
    checks++; if (cart_mask !== '0) begin errors++; $display("FAIL mid_mask: got %h, expected 0", cart_mask); end
    checks++; if (load_done !== 1'b0 || oversize !== 1'b0 || header_ok !== 1'b0) begin
      errors++; $display("FAIL mid_flags: got done=%b ovs=%b hdr=%b, expected 0/0/0", load_done, oversize, header_ok);
    end
    reset = 1'b0;
    tick();
    start_load();
    load_range(0, 512);
    end_load(1'b0, '0, '0);
    random_reads(8);
  endtask

  task automatic test_reload_in_hold();
    start_load();
    load_range(0, 2048);
    ioctl_download = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reload_hold%0d: got %b, expected 1", i, core_reset); end
    end
    start_load();
    load_range(0, 100);
    end_load(1'b0, '0, '0);
    checks++; if (cart_mask !== 15'h007F) begin errors++; $display("FAIL reload_mask: got %h, expected 007f", cart_mask); end
    random_reads(8);
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    model_clear();
    d = 8'($urandom);
    ioctl_download = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 25'h40; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    model_write(25'h40, d);
    checks++; if (cart_mask !== 15'h007F) begin errors++; $display("FAIL rise_wr_mask: got %h, expected 007f", cart_mask); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rise_wr_core_reset: got %b, expected 1", core_reset); end
    load_range(16'h41, 16);
    end_load(1'b1, 25'h100, 8'($urandom));
    checks++; if (cart_mask !== 15'h01FF) begin errors++; $display("FAIL fall_wr_mask: got %h, expected 01ff", cart_mask); end
    check_read(15'h0100);
    check_read(15'h0040);
    check_read(15'h7E40);
  endtask

  task automatic test_zero_length();
    start_load();
    end_load(1'b0, '0, '0);
    checks++; if (cart_mask !== '0) begin errors++; $display("FAIL zero_mask: got %h, expected 0", cart_mask); end
    random_reads(6);
  endtask

  task automatic test_header();
    start_load();
    for (int i = 0; i < 5; i++) drive_write(25'(i), hdr_ref[i]);
    load_range(5, 60);
    end_load(1'b0, '0, '0);
`ifdef CART_HEADER_CHECK_EN
    checks++; if (header_ok !== 1'b1) begin errors++; $display("FAIL header_good: got %b, expected 1", header_ok); end
`endif
    start_load();
    drive_write(25'h0, 8'h00);
    for (int i = 1; i < 5; i++) drive_write(25'(i), hdr_ref[i]);
    load_range(5, 60);
    end_load(1'b0, '0, '0);
`ifdef CART_HEADER_CHECK_EN
    checks++; if (header_ok !== 1'b0 || load_done !== 1'b1) begin
      errors++; $display("FAIL header_bad: got hdr=%b done=%b, expected 0/1", header_ok, load_done);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_addr = '0;
    model_clear();
    test_reset();
    test_load_8k();
    test_load_3000();
    test_oversize();
    test_reset_mid_load();
    test_reload_in_hold();
    test_simultaneous();
    test_zero_length();
    test_header();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
